// File: rtl/gfx_pkg.sv
// Shared graphics types: FIFO coordinate layout, default resolution, plotter FSM states.
package gfx_pkg;

  typedef logic [8:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pix_coord_t;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CHECK,
    ST_READ,
    ST_WAITQ,
    ST_CALC,
    ST_WRITE,
    ST_FINISH
  } plot_state_t;

endpackage

// File: rtl/plot_addr_calc.sv
// Combinational {x,y} -> linear framebuffer address, plus visible-area check.
// The range check is only real when PLOT_CLIP_EN is defined; otherwise in_range is 1.
module plot_addr_calc
  import gfx_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = 17
) (
  input  coord_t            i_x,
  input  coord_t            i_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_in_range
);

  logic [17:0] w_lin;

  // The framebuffer must hold the whole visible area.
  if (H_RES * V_RES > (1 << ADDR_W)) begin : g_bad_size
    $error("plot_addr_calc: H_RES*V_RES exceeds 2**ADDR_W");
  end

  always_comb begin
    w_lin  = 18'(i_y) * 18'(H_RES) + 18'(i_x);
    o_addr = w_lin[ADDR_W-1:0];
`ifdef PLOT_CLIP_EN
    o_in_range = (int'(i_x) < H_RES) && (int'(i_y) < V_RES);
`else
    o_in_range = 1'b1;
`endif
  end

endmodule

// File: rtl/line_pixel_plotter.sv
// Drains the rasterizer coordinate FIFO after each line and issues one handshaked
// framebuffer write per pixel. Define PLOT_CLIP_EN to drop off-screen pixels.
module line_pixel_plotter
  import gfx_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 17
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               line_done,
  input  logic [8:0]         fifo_count,
  input  logic [17:0]        fifo_q,
  output logic               fifo_rdreq,
  input  logic [COLOR_W-1:0] color,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  input  logic               fb_ack,
  output logic               busy,
  output logic               plot_done,
  output logic [8:0]         clip_count
);

  plot_state_t        r_state;
  plot_state_t        w_state_next;
  logic               r_line_done_q;
  logic [8:0]         r_remaining;
  logic [COLOR_W-1:0] r_col;
  coord_t             r_x;
  coord_t             r_y;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_in_range;
  logic               w_start_edge;
  pix_coord_t         w_pix;

  assign w_pix        = fifo_q;
  assign w_start_edge = line_done & ~r_line_done_q;

  plot_addr_calc #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .i_x        (r_x),
    .i_y        (r_y),
    .o_addr     (w_addr),
    .o_in_range (w_in_range)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_edge) w_state_next = ST_LATCH;
      ST_LATCH:  w_state_next = ST_CHECK;
      ST_CHECK:  w_state_next = (r_remaining == 9'd0) ? ST_FINISH : ST_READ;
      ST_READ:   w_state_next = ST_WAITQ;
      ST_WAITQ:  w_state_next = ST_CALC;
      ST_CALC:   w_state_next = w_in_range ? ST_WRITE : ST_CHECK;
      ST_WRITE:  if (fb_ack) w_state_next = ST_CHECK;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      r_line_done_q <= 1'b0;
      r_remaining   <= '0;
      r_col         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_line_done_q <= line_done;
      case (r_state)
        ST_LATCH: begin
          r_remaining <= fifo_count;
          r_col       <= color;
        end
        ST_READ:  r_remaining <= r_remaining - 9'd1;
        ST_WAITQ: begin
          r_x <= w_pix.x;
          r_y <= w_pix.y;
        end
        ST_CALC:  r_addr <= w_addr;
        default:  ;
      endcase
    end
  end

`ifdef PLOT_CLIP_EN
  logic [8:0] r_clip_count;

  // Saturating count of discarded pixels, cleared when a new line is latched.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_clip_count <= '0;
    end else if (r_state == ST_LATCH) begin
      r_clip_count <= '0;
    end else if (r_state == ST_CALC && !w_in_range && r_clip_count != 9'd511) begin
      r_clip_count <= r_clip_count + 9'd1;
    end
  end

  assign clip_count = r_clip_count;
`else
  assign clip_count = '0;
`endif

  assign fifo_rdreq = (r_state == ST_READ);
  assign fb_we      = (r_state == ST_WRITE);
  assign plot_done  = (r_state == ST_FINISH);
  assign busy       = (r_state != ST_IDLE);
  assign fb_addr    = r_addr;
  assign fb_data    = r_col;

endmodule

// File: tb/tb_line_pixel_plotter.sv
// Directed bench for line_pixel_plotter: FIFO and framebuffer-ack models with
// hand-computed addresses, cycle offsets and handshake counts.
module tb_line_pixel_plotter;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        line_done;
  logic [8:0]  fifo_count;
  logic [17:0] fifo_q;
  logic        fifo_rdreq;
  logic [7:0]  color;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ack = 1'b0;
  logic        busy;
  logic        plot_done;
  logic [8:0]  clip_count;

  line_pixel_plotter dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .line_done  (line_done),
    .fifo_count (fifo_count),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .color      (color),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ack     (fb_ack),
    .busy       (busy),
    .plot_done  (plot_done),
    .clip_count (clip_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_total = 0;
  int n_bad   = 0;

  logic [17:0] fifo_mem [0:63];
  int rd_ptr = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_we = 0;
  int n_wr = 0;
  int n_done = 0;
  int done_cyc = 0;
  int we_run = 0;
  int n_addr_chg = 0;
  int ack_delay = 0;
  logic        prev_we = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [16:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];

  // Registered-output FIFO: data appears the cycle after the read strobe.
  always @(posedge CLOCK_50) begin
    if (fifo_rdreq) begin
      fifo_q <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      n_rd   <= n_rd + 1;
    end
    if (fb_we) n_we <= n_we + 1;
    we_run <= fb_we ? we_run + 1 : 0;
    if (fb_we && fb_ack) begin
      wr_addr[n_wr] <= fb_addr;
      wr_data[n_wr] <= fb_data;
      n_wr <= n_wr + 1;
    end
    if (fb_we && prev_we && fb_addr != prev_addr) n_addr_chg <= n_addr_chg + 1;
    prev_we   <= fb_we;
    prev_addr <= fb_addr;
    if (plot_done) begin
      done_cyc <= cyc;
      n_done   <= n_done + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge CLOCK_50) fb_ack = fb_we && (we_run >= ack_delay);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Runs one line to plot_done and checks its timing and handshake counts.
  task automatic run_line(input string tag, input int cnt, input logic [7:0] col,
                          input int exp_off, input int exp_rd, input int exp_we);
    int base_rd, base_we, base_done, e, t;
    @(negedge CLOCK_50);
    fifo_count = 9'(cnt);
    color      = col;
    base_rd    = n_rd;
    base_we    = n_we;
    base_done  = n_done;
    e          = cyc;
    line_done  = 1'b1;
    @(negedge CLOCK_50);
    check_eq({tag, "_busy"}, 32'(busy), 1);
    t = 0;
    while (n_done == base_done && t < 300) begin
      @(negedge CLOCK_50);
      t++;
    end
    check_eq({tag, "_done_seen"}, 32'(n_done != base_done), 1);
    check_eq({tag, "_done_off"}, 32'(done_cyc - e), 32'(exp_off));
    repeat (3) @(negedge CLOCK_50);
    check_eq({tag, "_no_retrig"}, 32'(busy), 0);
    check_eq({tag, "_rdreq"}, 32'(n_rd - base_rd), 32'(exp_rd));
    check_eq({tag, "_we_cyc"}, 32'(n_we - base_we), 32'(exp_we));
    line_done = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic load(input int i, input int x, input int y);
    fifo_mem[rd_ptr + i] = {9'(x), 9'(y)};
  endtask

  initial begin
    int base_wr, base_chg, t;
    RESET_N    = 1'b0;
    line_done  = 1'b0;
    fifo_count = '0;
    color      = '0;

    repeat (2) @(negedge CLOCK_50);
    check_eq("rst_rdreq", 32'(fifo_rdreq), 0);
    check_eq("rst_we", 32'(fb_we), 0);
    check_eq("rst_addr", 32'(fb_addr), 0);
    check_eq("rst_data", 32'(fb_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(plot_done), 0);
    check_eq("rst_clip", 32'(clip_count), 0);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_activity", 32'(n_rd + n_we), 0);

    // Three pixels, immediate ack
    ack_delay = 0;
    base_wr = n_wr;
    load(0, 10, 20); load(1, 11, 20); load(2, 12, 21);
    run_line("tri", 3, 8'hE0, 18, 3, 3);
    check_eq("tri_nwr", 32'(n_wr - base_wr), 3);
    check_eq("tri_a0", 32'(wr_addr[base_wr]), 6410);
    check_eq("tri_a1", 32'(wr_addr[base_wr + 1]), 6411);
    check_eq("tri_a2", 32'(wr_addr[base_wr + 2]), 6732);
    check_eq("tri_d0", 32'(wr_data[base_wr]), 32'h E0);
    check_eq("tri_d2", 32'(wr_data[base_wr + 2]), 32'h E0);

    // Back-pressure: ack three cycles after fb_we rises
    ack_delay = 3;
    base_wr  = n_wr;
    base_chg = n_addr_chg;
    load(0, 0, 1);
    run_line("bp", 1, 8'h5A, 11, 1, 4);
    check_eq("bp_addr", 32'(wr_addr[base_wr]), 320);
    check_eq("bp_data", 32'(wr_data[base_wr]), 32'h5A);
    check_eq("bp_addr_stable", 32'(n_addr_chg - base_chg), 0);
    ack_delay = 0;

    // Empty line
    run_line("empty", 0, 8'h11, 3, 0, 0);

    // Off-screen pixel followed by a visible one
    base_wr = n_wr;
    load(0, 330, 5); load(1, 5, 5);
`ifdef PLOT_CLIP_EN
    run_line("clip", 2, 8'h33, 12, 2, 1);
    check_eq("clip_nwr", 32'(n_wr - base_wr), 1);
    check_eq("clip_addr", 32'(wr_addr[base_wr]), 1605);
    check_eq("clip_count", 32'(clip_count), 1);
`else
    run_line("noclip", 2, 8'h33, 13, 2, 2);
    check_eq("noclip_nwr", 32'(n_wr - base_wr), 2);
    check_eq("noclip_a0", 32'(wr_addr[base_wr]), 1930);
    check_eq("noclip_a1", 32'(wr_addr[base_wr + 1]), 1605);
    check_eq("noclip_count", 32'(clip_count), 0);
`endif

    // Reset while a write is pending
    ack_delay = 1000;
    load(0, 7, 0);
    @(negedge CLOCK_50);
    fifo_count = 9'd1;
    line_done  = 1'b1;
    t = 0;
    while (!fb_we && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    check_eq("mid_we_seen", 32'(fb_we), 1);
    RESET_N   = 1'b0;
    line_done = 1'b0;
    @(negedge CLOCK_50);
    check_eq("mid_rst_we", 32'(fb_we), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_rdreq", 32'(fifo_rdreq), 0);
    RESET_N   = 1'b1;
    ack_delay = 0;
    repeat (2) @(negedge CLOCK_50);
    base_wr = n_wr;
    load(0, 2, 3);
    run_line("restart", 1, 8'h77, 8, 1, 1);
    check_eq("restart_addr", 32'(wr_addr[base_wr]), 962);
    check_eq("restart_data", 32'(wr_data[base_wr]), 32'h77);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/line_pixel_plotter.md
# line_pixel_plotter

Downstream stage of the line rasterizer. Drains the rasterizer's 18-bit coordinate FIFO once a line completes, converts each `{x,y}` pair into a linear framebuffer address, and issues one handshaked framebuffer write per pixel with a per-line colour. It sits between the rasterizer and the framebuffer write arbiter.

## Interface
- `H_RES`, 320, visible width in pixels
- `V_RES`, 240, visible height in pixels
- `COLOR_W`, 8, pixel colour width
- `ADDR_W`, 17, framebuffer word-address width; must satisfy `H_RES*V_RES <= 2**ADDR_W`

Ports:
- `CLOCK_50` in 1: single clock; all logic on its rising edge.
- `RESET_N` in 1: synchronous, active-low reset.
- `line_done` in 1: rasterizer done level; only its rising edge is used.
- `fifo_count` in 9: rasterizer pixel count for the finished line.
- `fifo_q` in 18: FIFO read data; `x = [17:9]`, `y = [8:0]`; valid one cycle after `fifo_rdreq`.
- `fifo_rdreq` out 1: FIFO read strobe, one cycle per entry.
- `color` in COLOR_W: line colour, sampled at line start.
- `fb_addr` out ADDR_W: write address.
- `fb_data` out COLOR_W: write data.
- `fb_we` out 1: write request, held until acknowledged.
- `fb_ack` in 1: write accepted; sampled only while `fb_we=1`.
- `busy` out 1: high from LATCH through FINISH.
- `plot_done` out 1: one-cycle pulse when the line is fully drained.
- `clip_count` out 9: pixels discarded in the current line.

## Operation
- The rasterizer's FIFO count never decrements, so the block keeps its own `remaining` counter (9 bits).
- Rising-edge detection uses a `line_done_q` register: `start_edge = line_done & ~line_done_q`.
- FSM states: IDLE, LATCH, CHECK, READ, WAITQ, CALC, WRITE, FINISH.
  - IDLE: on `start_edge`, go to LATCH. Any other input is ignored.
  - LATCH: `remaining <= fifo_count`; `col_r <= color`; `clip_count <= 0`; go to CHECK.
  - CHECK: if `remaining==0`, go to FINISH; else go to READ.
  - READ: `fifo_rdreq=1` for exactly this cycle; `remaining--`; go to WAITQ.
  - WAITQ: register `fifo_q` into `x_r`/`y_r`; go to CALC.
  - CALC: compute the address as `y_r*H_RES + x_r` in a 18-bit intermediate, truncated to ADDR_W, and register it.
    - If the pixel is kept, go to WRITE.
    - If it is clipped, increment `clip_count` (saturating at 511) and go to CHECK.
  - WRITE: hold `fb_we=1` with `fb_addr`/`fb_data=col_r` stable. When `fb_ack=1`, go to CHECK next cycle.
  - FINISH: `plot_done=1` for this one cycle; go to IDLE.
- A `start_edge` arriving while `busy` is ignored. The upstream controller must not start a new line before `plot_done`.
- Reset values: `fifo_rdreq=0`, `fb_we=0`, `fb_addr=0`, `fb_data=0`, `busy=0`, `plot_done=0`, `clip_count=0`, state IDLE, `line_done_q=0`.
- Reset mid-line: the block is in IDLE with `fb_we`/`fifo_rdreq` low on the cycle after `RESET_N` is sampled low. FIFO contents are not flushed; that is the rasterizer's responsibility.

## Timing
- Edge to first `fifo_rdreq`: edge at cycle E gives LATCH at E+1, CHECK at E+2, READ at E+3.
- Per pixel: READ, WAITQ, CALC, WRITE(≥1), CHECK. That is 5 cycles per pixel with immediate `fb_ack`, plus 1 cycle per extra ack wait.
- Clipped pixel: 4 cycles, no `fb_we`.
- Empty line: `plot_done` at E+3.
- `fb_ack` arriving while `fb_we=0` has no effect.

## Configuration
- `PLOT_CLIP_EN` defined: in CALC, a pixel with `x_r >= H_RES` or `y_r >= V_RES` is dropped and counted in `clip_count`. Its FIFO entry is still consumed.
- `PLOT_CLIP_EN` undefined: no range check and no CALC branch. Every pixel is written with a truncated address, and `clip_count` is tied to 0.

## Structure
- Shared package `gfx_pkg`:
  - `coord_t` (logic [8:0])
  - packed struct `pix_coord_t {coord_t x; coord_t y;}` matching the FIFO layout
  - default `H_RES`/`V_RES` localparams
  - FSM state enum `plot_state_t`
- One sub-module, `plot_addr_calc`: purely combinational; takes x/y and produces `addr` and `in_range`. Instanced in CALC; `in_range` is forced to 1 without the macro.

## Test plan
- Reset: hold `RESET_N=0` 2 cycles → all outputs 0, state IDLE; release → no activity until a `line_done` edge.
- Three-pixel line: count=3, FIFO (10,20),(11,20),(12,21), `color=8'hE0`, immediate ack → writes to addresses 6410, 6411, 6732 with data E0; exactly 3 `fifo_rdreq`; `plot_done` at E+18.
- Back-pressure: one pixel (0,1), `fb_ack` asserted 3 cycles after `fb_we` rises → `fb_we` high 4 cycles; `fb_addr=320` is stable throughout.
- Empty line: count=0 → no `fifo_rdreq`, no `fb_we`, `plot_done` at E+3.
- Clip with `PLOT_CLIP_EN`: FIFO (330,5),(5,5) → one write to address 1605; `clip_count=1`; 2 `fifo_rdreq`.
- Reset mid-WRITE: drop `RESET_N` while `fb_we=1` → `fb_we=0` and `busy=0` the next cycle; a new edge then restarts cleanly.
